fetch_pc_unit: RTL and testbench

- Parametrised successor to the single-cycle PC path (pc_reg + PC_control): generates the fetch PC for the pipelined WISC core.
- Predicts branches using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Accepts branch resolutions from execute and issues one-cycle redirect/flush on misprediction.
- Sits between instruction memory address input and the IF/ID pipeline register.

---
 rtl/fetch_pc_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Fetch PC generator for the pipelined WISC core. Predicts the next
//            PC with a direct-mapped BTB holding 2-bit saturating counters,
//            accepts branch resolutions from execute, and redirects/flushes
//            the front end in the same cycle a misprediction is resolved.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            stall_i                   - hold the PC this cycle
//            halt_i                    - committed HLT, sets sticky hlt_o
//            resolve_*_i               - branch resolution from execute
//            pc_o                      - current fetch PC
//            pred_taken_o/pred_target_o- prediction for the instruction at pc_o
//            flush_o                   - squash IF/ID and ID/EX
//            hlt_o                     - sticky halt
// Options  : BTB_STATS_EN adds stat_resolves_o / stat_mispredicts_o counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              halt_i,
    input  logic              resolve_valid_i,
    input  logic [ADDR_W-1:0] resolve_pc_i,
    input  logic              resolve_taken_i,
    input  logic [ADDR_W-1:0] resolve_target_i,
    input  logic              resolve_pred_taken_i,
    input  logic [ADDR_W-1:0] resolve_pred_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    output logic              flush_o,
    output logic              hlt_o
`ifdef BTB_STATS_EN
    ,
    output logic [15:0]       stat_resolves_o,
    output logic [15:0]       stat_mispredicts_o
`endif
);

    localparam int                IDX_W     = $clog2(BTB_ENTRIES);
    localparam int                TAG_W     = ADDR_W - IDX_W - 1;
    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(2);

    // Branch target buffer storage
    logic              r_valid  [BTB_ENTRIES];
    logic [1:0]        r_ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0]  r_tag    [BTB_ENTRIES];
    logic [ADDR_W-1:0] r_target [BTB_ENTRIES];

    logic [ADDR_W-1:0] r_pc;
    logic              r_hlt;

    // Lookup side (current fetch PC)
    logic [IDX_W-1:0]  w_idx;
    logic              w_hit;
    logic [ADDR_W-1:0] w_pc_plus2;

    // Resolve side
    logic [IDX_W-1:0]  w_res_idx;
    logic              w_res_hit;
    logic [ADDR_W-1:0] w_correct_pc;
    logic              w_mispredict;
    logic              w_accept;

    assign w_idx        = r_pc[IDX_W:1];
    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == r_pc[ADDR_W-1:IDX_W+1]);
    assign w_pc_plus2   = r_pc + c_PC_STEP;

    assign pc_o          = r_pc;
    assign hlt_o         = r_hlt;
    assign pred_taken_o  = w_hit & r_ctr[w_idx][1];
    assign pred_target_o = pred_taken_o ? r_target[w_idx] : w_pc_plus2;

    assign w_res_idx    = resolve_pc_i[IDX_W:1];
    assign w_res_hit    = r_valid[w_res_idx] &&
                          (r_tag[w_res_idx] == resolve_pc_i[ADDR_W-1:IDX_W+1]);
    assign w_correct_pc = resolve_taken_i ? resolve_target_i : (resolve_pc_i + c_PC_STEP);
    assign w_mispredict = resolve_valid_i &
                          ((resolve_taken_i != resolve_pred_taken_i) |
                           (resolve_taken_i & (resolve_target_i != resolve_pred_target_i)));

    // A resolve in the same cycle as a committed HLT is discarded.
    assign w_accept = resolve_valid_i & ~r_hlt & ~halt_i;

    // Zero-latency flush; held low while in reset.
    assign flush_o = w_mispredict & ~r_hlt & ~rst;

    // PC and sticky halt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC;
            r_hlt <= 1'b0;
        end else if (r_hlt | halt_i) begin
            r_hlt <= 1'b1;
        end else if (w_mispredict) begin
            r_pc <= w_correct_pc;
        end else if (!stall_i) begin
            r_pc <= pred_target_o;
        end
    end

    // BTB update; independent of stall_i
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_ctr[i]    <= 2'b01;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (w_accept) begin
            if (w_res_hit) begin
                if (resolve_taken_i) begin
                    if (r_ctr[w_res_idx] != 2'b11) begin
                        r_ctr[w_res_idx] <= r_ctr[w_res_idx] + 2'b01;
                    end
                    r_target[w_res_idx] <= resolve_target_i;
                end else if (r_ctr[w_res_idx] != 2'b00) begin
                    r_ctr[w_res_idx] <= r_ctr[w_res_idx] - 2'b01;
                end
            end else if (resolve_taken_i) begin
                r_valid[w_res_idx]  <= 1'b1;
                r_tag[w_res_idx]    <= resolve_pc_i[ADDR_W-1:IDX_W+1];
                r_target[w_res_idx] <= resolve_target_i;
                r_ctr[w_res_idx]    <= 2'b10;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [15:0] r_stat_res;
    logic [15:0] r_stat_mp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_res <= 16'h0000;
            r_stat_mp  <= 16'h0000;
        end else begin
            if (w_accept && (r_stat_res != 16'hFFFF)) begin
                r_stat_res <= r_stat_res + 16'h0001;
            end
            if (flush_o && (r_stat_mp != 16'hFFFF)) begin
                r_stat_mp <= r_stat_mp + 16'h0001;
            end
        end
    end

    assign stat_resolves_o    = r_stat_res;
    assign stat_mispredicts_o = r_stat_mp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_unit
// Purpose  : Self-checking bench for fetch_pc_unit: directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a behavioural BTB/PC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam int c_N     = 16;
    localparam int c_IDX_W = 4;

    logic        clk = 1'b0;
    logic        rst, stall, halt, rv, rtk, rptk;
    logic [15:0] rpc, rtgt, rptgt;
    logic [15:0] pc_o, pred_target_o;
    logic        pred_taken_o, flush_o, hlt_o;
`ifdef BTB_STATS_EN
    logic [15:0] stat_res, stat_mp;
`endif

    fetch_pc_unit #(.ADDR_W(16), .BTB_ENTRIES(c_N), .RESET_PC(16'h0000)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .stall_i               (stall),
        .halt_i                (halt),
        .resolve_valid_i       (rv),
        .resolve_pc_i          (rpc),
        .resolve_taken_i       (rtk),
        .resolve_target_i      (rtgt),
        .resolve_pred_taken_i  (rptk),
        .resolve_pred_target_i (rptgt),
        .pc_o                  (pc_o),
        .pred_taken_o          (pred_taken_o),
        .pred_target_o         (pred_target_o),
        .flush_o               (flush_o),
        .hlt_o                 (hlt_o)
`ifdef BTB_STATS_EN
        ,
        .stat_resolves_o       (stat_res),
        .stat_mispredicts_o    (stat_mp)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    bit          model_ok = 0;
    logic [15:0] m_pc;
    bit          m_hlt;
    bit          m_valid [c_N];
    int          m_tag   [c_N];
    int          m_ctr   [c_N];
    logic [15:0] m_tgt   [c_N];

    function automatic int bidx(input logic [15:0] a);
        return (int'(a) >> 1) % c_N;
    endfunction
    function automatic int btag(input logic [15:0] a);
        return int'(a) >> (c_IDX_W + 1);
    endfunction
    function automatic bit m_hit(input logic [15:0] a);
        return m_valid[bidx(a)] && (m_tag[bidx(a)] == btag(a));
    endfunction
    function automatic bit m_ptk(input logic [15:0] a);
        return m_hit(a) && (m_ctr[bidx(a)] >= 2);
    endfunction
    function automatic logic [15:0] m_ptgt(input logic [15:0] a);
        return m_ptk(a) ? m_tgt[bidx(a)] : 16'(a + 16'd2);
    endfunction
    function automatic bit m_mp();
        return rv && ((rtk != rptk) || (rtk && (rtgt != rptgt)));
    endfunction

    always @(posedge clk) begin : model_upd
        logic [15:0] nxt;
        int          i;
        if (rst) begin
            model_ok = 1;
            m_pc     = 16'h0000;
            m_hlt    = 0;
            for (int k = 0; k < c_N; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_ctr[k] = 1; m_tgt[k] = 16'h0;
            end
        end else if (model_ok) begin
            nxt = m_pc;
            if (m_hlt || halt)  nxt = m_pc;
            else if (m_mp())    nxt = rtk ? rtgt : 16'(rpc + 16'd2);
            else if (!stall)    nxt = m_ptgt(m_pc);
            if (rv && !m_hlt && !halt) begin
                i = bidx(rpc);
                if (m_hit(rpc)) begin
                    if (rtk) begin
                        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                        m_tgt[i] = rtgt;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                end else if (rtk) begin
                    m_valid[i] = 1; m_tag[i] = btag(rpc); m_tgt[i] = rtgt; m_ctr[i] = 2;
                end
            end
            if (halt) m_hlt = 1;
            m_pc = nxt;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            check("m_pc",          {16'h0, pc_o},          {16'h0, m_pc});
            check("m_hlt",         {31'h0, hlt_o},         {31'h0, m_hlt});
            check("m_pred_taken",  {31'h0, pred_taken_o},  {31'h0, m_ptk(m_pc)});
            check("m_pred_target", {16'h0, pred_target_o}, {16'h0, m_ptgt(m_pc)});
            check("m_flush",       {31'h0, flush_o},       {31'h0, (!rst && !m_hlt && m_mp())});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic res(input logic [15:0] p, input logic t, input logic [15:0] g,
                       input logic pt, input logic [15:0] pg);
        rv = 1; rpc = p; rtk = t; rtgt = g; rptk = pt; rptgt = pg;
    endtask
    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        check(name, {16'h0, act}, {16'h0, exp});
    endtask

    function automatic logic [15:0] pick_pc();
        case ($urandom_range(0, 5))
            0: return 16'h0004;
            1: return 16'h0024;
            2: return 16'h0010;
            3: return 16'h0030;
            4: return m_pc;
            default: return 16'($urandom) & 16'hFFFE;
        endcase
    endfunction
    function automatic logic [15:0] pick_tgt(input logic [15:0] p);
        case ($urandom_range(0, 4))
            0: return 16'h0040;
            1: return 16'h0080;
            2: return 16'h0200;
            3: return 16'(p + 16'd2);
            default: return 16'($urandom) & 16'hFFFE;
        endcase
    endfunction

    initial begin
        rst = 1; stall = 0; halt = 0; rv = 0;
        rpc = 0; rtk = 0; rtgt = 0; rptk = 0; rptgt = 0;
        repeat (2) step();
        rst = 0;
        #1;
        lit("rst_pc", pc_o, 16'h0000);
        lit("rst_hlt", {15'h0, hlt_o}, 16'h0);
        lit("rst_pred", {15'h0, pred_taken_o}, 16'h0);
        lit("rst_flush", {15'h0, flush_o}, 16'h0);
        step(); #1 lit("run_pc2", pc_o, 16'h0002);
        step(); #1 lit("run_pc4", pc_o, 16'h0004);
        step(); #1 lit("run_pc6", pc_o, 16'h0006);

        // first taken resolve allocates, redirect to 0x40
        res(16'h0004, 1, 16'h0040, 0, 16'h0006);
        #1 lit("alloc_flush", {15'h0, flush_o}, 16'h1);
        step(); rv = 0;
        #1 lit("alloc_pc", pc_o, 16'h0040);
        res(16'h0002, 0, 16'h0000, 1, 16'h0040);
        step(); rv = 0; stall = 1;
        #1 lit("hit_pc", pc_o, 16'h0004);
        lit("ctr10_pred", {15'h0, pred_taken_o}, 16'h1);
        lit("ctr10_tgt", pred_target_o, 16'h0040);

        // counter walk 10->11->11->10->01->00 while stalled at 0x0004
        res(16'h0004, 1, 16'h0040, 1, 16'h0040);
        #1 lit("tk_noflush", {15'h0, flush_o}, 16'h0);
        step(); #1 lit("ctr11a_pred", {15'h0, pred_taken_o}, 16'h1);
        step(); rv = 0;
        #1 lit("ctr11b_pred", {15'h0, pred_taken_o}, 16'h1);
        res(16'h0004, 0, 16'h0000, 1, 16'h0040);
        #1 lit("nt_flush", {15'h0, flush_o}, 16'h1);
        step(); rv = 0;
        #1 lit("nt_pc", pc_o, 16'h0006);
        res(16'h0002, 0, 16'h0000, 1, 16'h0040);
        step(); rv = 0;
        #1 lit("ctr10b_pred", {15'h0, pred_taken_o}, 16'h1);
        res(16'h0004, 0, 16'h0000, 0, 16'h0006);
        step();
        #1 lit("ctr01_pred", {15'h0, pred_taken_o}, 16'h0);
        lit("ctr01_tgt", pred_target_o, 16'h0006);
        step(); rv = 0;
        #1 lit("ctr00_pred", {15'h0, pred_taken_o}, 16'h0);
        lit("stall_hold_pc", pc_o, 16'h0004);

        // mispredict overrides stall, then stall holds
        res(16'h0050, 1, 16'h0100, 0, 16'h0006);
        #1 lit("stallmp_flush", {15'h0, flush_o}, 16'h1);
        step(); rv = 0;
        #1 lit("stallmp_pc", pc_o, 16'h0100);
        for (int k = 0; k < 3; k++) begin
            step(); #1 lit("stall_pc", pc_o, 16'h0100);
        end

        // wrap at 0xFFFE
        res(16'hFFFC, 0, 16'h0000, 1, 16'h0000);
        step(); rv = 0; stall = 0;
        #1 lit("wrap_pc", pc_o, 16'hFFFE);
        lit("wrap_tgt", pred_target_o, 16'h0000);
        step(); #1 lit("wrap_next", pc_o, 16'h0000);

        // alias 0x0024 replaces the 0x0004 entry
        res(16'h0024, 1, 16'h0080, 0, 16'h0002);
        step(); rv = 0;
        #1 lit("alias_pc", pc_o, 16'h0080);
        res(16'h0002, 0, 16'h0000, 1, 16'h0040);
        step(); rv = 0;
        #1 lit("alias_at4", pc_o, 16'h0004);
        lit("alias_miss", {15'h0, pred_taken_o}, 16'h0);
        lit("alias_tgt", pred_target_o, 16'h0006);

        // halt with a concurrent mispredict
        halt = 1;
        res(16'h0004, 1, 16'h0200, 0, 16'h0006);
        step(); halt = 0; rv = 0;
        #1 lit("halt_hlt", {15'h0, hlt_o}, 16'h1);
        lit("halt_pc", pc_o, 16'h0004);
        lit("halt_nobtb", {15'h0, pred_taken_o}, 16'h0);
        res(16'h0004, 1, 16'h0200, 0, 16'h0006);
        #1 lit("halt_noflush", {15'h0, flush_o}, 16'h0);
        step(); rv = 0;
        #1 lit("halt_frozen", pc_o, 16'h0004);
        rst = 1;
        step(); rst = 0;
        #1 lit("rst2_pc", pc_o, 16'h0000);
        lit("rst2_hlt", {15'h0, hlt_o}, 16'h0);
        step(); step();
        #1 lit("rst2_miss", {15'h0, pred_taken_o}, 16'h0);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            step();
            rst   = m_hlt ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 999) == 0);
            halt  = !m_hlt && ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 3) == 0);
            rv    = ($urandom_range(0, 2) == 0);
            rpc   = pick_pc();
            rtk   = 1'($urandom_range(0, 1));
            rtgt  = pick_tgt(rpc);
            rptk  = ($urandom_range(0, 2) != 0) ? m_ptk(rpc) : 1'($urandom_range(0, 1));
            rptgt = ($urandom_range(0, 2) != 0) ? rtgt : pick_tgt(rpc);
        end
        step();
        rst = 0; halt = 0; rv = 0; stall = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
